// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, the
// active-low hex decode table and the "everything off" drive levels.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low cathode patterns {CA,CB,CC,CD,CE,CF,CG}; element n is hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup; the table already holds active-low patterns
  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous
// value updates and registered anode/cathode drives.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always lit).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic [6:0]  segments,
  output logic [7:0]  anodos
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [2:0]       digit_idx;
  logic [31:0]      shadow;
  logic [31:0]      display;
  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic [7:0]       an_next;
  logic             blank;

  assign slot_end  = (prescaler == CNT_LAST);
  assign frame_end = slot_end && (digit_idx == 3'd7);

  // Prescaler sets the slot length; its terminal count steps the digit index
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= 3'd0;
    end else if (slot_end) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

  // Shadow register keeps the most recent strobed value
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= 32'd0;
    end else if (value_valid) begin
      shadow <= value_in;
    end
  end

  // Display register changes only at the 7->0 wrap, so a frame is never mixed;
  // a strobe on the wrap cycle lands in shadow too late and waits a frame
  always_ff @(posedge clock) begin
    if (reset) begin
      display <= 32'd0;
    end else if (frame_end) begin
      display <= shadow;
    end
  end

  assign nibble  = display[{digit_idx, 2'b00} +: 4];
  assign an_next = ~(8'b0000_0001 << digit_idx);

  hex_to_7seg u_decoder (
    .hex (nibble),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 is blank when it and every higher nibble are zero
  always_comb begin
    blank = 1'b0;
    if (digit_idx != 3'd0) begin
      blank = ((display >> {digit_idx, 2'b00}) == 32'd0);
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Output drives are registered, trailing the digit index by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      anodos   <= AN_OFF;
      segments <= SEG_OFF;
    end else if (blank) begin
      anodos   <= AN_OFF;
      segments <= SEG_OFF;
    end else begin
      anodos   <= an_next;
      segments <= dec_seg;
    end
  end

endmodule
